sram_req_arbiter: RTL
=====================

# sram_req_arbiter

Two-master arbiter that shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EX issues, MEM consumes `rdata`). It grants one address phase per cycle with fixed data-over-inst priority. It holds the grant until `addr_ok`, then tracks outstanding transactions in an in-order ID FIFO so each `data_ok`/`rdata` is returned to the requester that issued it. It sits between the pipeline stages and the memory-side bridge.

## Interface
- `OUTSTANDING`, 2: max accepted-but-unanswered transactions; power of two, ≥1.
- `clk`  in  1  sole clock, all state on posedge.
- `resetn`  in  1  synchronous, active-low reset.
- `inst_req`  in  1  IF address-phase request (always read).
- `inst_addr`  in  32  fetch address.
- `inst_addr_ok`  out  1  IF address phase accepted this cycle.
- `inst_data_ok`  out  1  IF read data valid this cycle.
- `inst_rdata`  out  32  fetch data.
- `data_req`  in  1  data address-phase request.
- `data_wr`  in  1  1 = store, 0 = load.
- `data_size`  in  2  0 = byte, 1 = half, 2 = word.
- `data_wstrb`  in  4  byte enables for stores.
- `data_addr`  in  32  data address.
- `data_wdata`  in  32  store data.
- `data_addr_ok`  out  1  data address phase accepted.
- `data_data_ok`  out  1  load data returned, or store completion.
- `data_rdata`  out  32  load data; MEM does byte/half extraction.
- `mem_req`, `mem_wr`, `mem_size[1:0]`, `mem_wstrb[3:0]`, `mem_addr[31:0]`, `mem_wdata[31:0]`  out: shared port request.
- `mem_addr_ok`, `mem_data_ok`  in  1: shared port handshakes.
- `mem_rdata`  in  32: shared port read data.
- `err`  out  1: sticky protocol error (`mem_data_ok` with no outstanding ID).

## Operation
- FSM `grant_st`: IDLE, HOLD_I, HOLD_D.
  - IDLE: if FIFO not full, select `data` if `data_req`, else `inst` if `inst_req`.
    - Same-cycle `mem_addr_ok` → stay IDLE, push the winner's ID.
    - No `mem_addr_ok` → go to HOLD_D or HOLD_I.
  - HOLD_x: drive only requester x, regardless of the other's `req`. On `mem_addr_ok`, push ID x and go to IDLE.
  - Requesters keep request fields stable until `addr_ok`, per the SRAM-like protocol. The arbiter never rescinds a presented `mem_req`.
- Mux: `mem_*` carries the selected requester's fields. Inst is forced to `wr=0`, `size=2`, `wstrb=0`, `wdata=0`. With no selection, all `mem_*` = 0.
- `inst_addr_ok` = `mem_addr_ok` & inst selected; `data_addr_ok` likewise for data. The unselected requester sees 0.
- ID FIFO: width 1 (0 = inst, 1 = data), depth `OUTSTANDING`.
  - Push on `mem_req & mem_addr_ok`.
  - Pop on `mem_data_ok` when not empty.
  - Push and pop in the same cycle: count unchanged, pointers both advance and wrap mod `OUTSTANDING`.
- Response routing:
  - `inst_data_ok` = `mem_data_ok` & head==0.
  - `data_data_ok` = `mem_data_ok` & head==1.
  - `inst_rdata` and `data_rdata` both equal `mem_rdata`; only the matching `data_ok` qualifies it.
- Full (count==`OUTSTANDING`): `mem_req`=0 in IDLE. A HOLD state cannot occur while full, because the hold began with count < `OUTSTANDING` and no push has happened since.
- `mem_data_ok` while empty: no pop, no `*_data_ok`, and `err` sets and stays set until reset.

## Timing
- Request path is combinational: `*_req` to `mem_req` in 0 cycles, `mem_addr_ok` to `*_addr_ok` in 0 cycles.
- Response path is combinational: `mem_data_ok`/`mem_rdata` to `*_data_ok`/`*_rdata` in 0 cycles.
- Responses may return in the cycle after acceptance at the earliest. A same-cycle accept and response for the same transaction is not supported.
- Reset:
  - `grant_st`=IDLE, FIFO count/pointers=0, `err`=0.
  - All outputs 0, because no selection exists and the FIFO is empty.
  - Reset mid-transaction discards all outstanding IDs. The memory side is reset in the same cycle.
- Throughput: one accept per cycle while not full.
- Count is registered: a pop in the cycle where count==`OUTSTANDING` does not allow a same-cycle push.

## Structure
- Shared package holds:
  - `ID_INST`=1'b0, `ID_DATA`=1'b1.
  - `grant_st` encodings IDLE=2'd0, HOLD_I=2'd1, HOLD_D=2'd2.
  - `SIZE_WORD`=2'd2.
- One sub-module: `req_id_fifo`, a synchronous 1-bit FIFO parameterised by depth, with push, pop, head, full, empty.

## Test plan
- Both `req` high in IDLE, `mem_addr_ok`=1 → data wins; `data_addr_ok`=1, `inst_addr_ok`=0, FIFO head=1.
- Inst presented, `mem_addr_ok` low for 3 cycles, `data_req` rises at cycle 1 → `mem_addr` stays `inst_addr` until accept; data is granted the next cycle.
- Accept inst@0x1c000000 then data load@0x1c000100; return `mem_rdata`=0xAAAA5555 then 0x12345678 → `inst_data_ok` with 0xAAAA5555, then `data_data_ok` with 0x12345678.
- `OUTSTANDING`=2, two accepts, no responses → `mem_req`=0 despite requests. One `mem_data_ok` → `mem_req` reasserts the next cycle.
- Simultaneous push and pop at count 1 for 8 cycles → count stays 1; pointers wrap with correct ID order.
- `mem_data_ok` pulse with FIFO empty → no `*_data_ok`, `err`=1 held. `resetn`=0 one cycle → `err`=0, all outputs 0.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter.
//   ID_INST / ID_DATA : requester tags stored in the outstanding-ID FIFO
//   grant_st_e        : grant FSM states
//   SIZE_WORD         : transfer size forced onto instruction fetches
package sram_req_arbiter_pkg;

    localparam logic       ID_INST   = 1'b0;
    localparam logic       ID_DATA   = 1'b1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } grant_st_e;

endpackage

// File: rtl/req_id_fifo.sv
// Synchronous 1-bit FIFO recording which requester owns each outstanding
// memory transaction, in issue order.
//   clk, resetn : clock, synchronous active-low reset
//   push, id_in : enqueue id_in (ignored when full)
//   pop         : dequeue the head (ignored when empty)
//   head        : oldest stored ID
//   full, empty : occupancy flags (registered count)
module req_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic id_in,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= id_in;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-master arbiter sharing one SRAM-like port between instruction fetch
// and data access. Data has fixed priority; a presented request is held
// until mem_addr_ok, and responses are routed back in order via an ID FIFO.
//   clk, resetn              : clock, synchronous active-low reset
//   inst_*                   : instruction-fetch requester (read only)
//   data_*                   : data requester (load/store)
//   mem_*                    : shared memory-side port
//   err                      : sticky flag, mem_data_ok with nothing outstanding
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    grant_st_e state;
    grant_st_e state_nxt;
    logic      sel_i;
    logic      sel_d;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_head;
    logic      push;
    logic      pop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A HOLD state keeps its requester selected even if the FIFO is full,
    // which cannot happen: the hold began below OUTSTANDING with no push since.
    always_comb begin
        state_nxt = state;
        sel_i     = 1'b0;
        sel_d     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_full) begin
                    if (data_req) begin
                        sel_d = 1'b1;
                        if (!mem_addr_ok) state_nxt = HOLD_D;
                    end else if (inst_req) begin
                        sel_i = 1'b1;
                        if (!mem_addr_ok) state_nxt = HOLD_I;
                    end
                end
            end
            HOLD_I: begin
                sel_i = 1'b1;
                if (mem_addr_ok) state_nxt = IDLE;
            end
            HOLD_D: begin
                sel_d = 1'b1;
                if (mem_addr_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sel_d) begin
            mem_req   = 1'b1;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (sel_i) begin
            mem_req   = 1'b1;
            mem_size  = SIZE_WORD;
            mem_addr  = inst_addr;
        end
    end

    assign inst_addr_ok = mem_addr_ok & sel_i;
    assign data_addr_ok = mem_addr_ok & sel_d;

    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & ~fifo_empty;

    req_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .id_in  (sel_d ? ID_DATA : ID_INST),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign inst_data_ok = pop & (fifo_head == ID_INST);
    assign data_data_ok = pop & (fifo_head == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (mem_data_ok && fifo_empty) begin
            err <= 1'b1;
        end
    end

endmodule
